// File: rtl/stage_sequencer.sv
// stage_sequencer: steps the picoMips datapath through its four-phase
// instruction cycle (fetch, decode, execute, writeback), owns the program
// counter, resolves decoder PC hold requests and synchronises the external
// handshake line.
//
// Optional feature: define SINGLE_STEP_EN to add the StepReq input, which runs
// exactly one instruction from IDLE per synchronised rising edge.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset       synchronous, active-high reset
//   Run         enables sequencing; low parks in IDLE at the next stage-0 boundary
//   HandshakeIn asynchronous external handshake line
//   PCHold      decoder hold request, sampled only in stage 3 / WAIT
//   StepReq     (SINGLE_STEP_EN only) asynchronous single-step request
//   Stage       current phase: 0 fetch, 1 decode, 2 execute, 3 writeback
//   PC          current instruction address
//   Handshake   HandshakeIn delayed through SYNC_STAGES flops
//   Stalled     high while in WAIT
//   Idle        high while in IDLE
module stage_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned PROG_LEN    = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Run,
  input  logic                HandshakeIn,
  input  logic                PCHold,
`ifdef SINGLE_STEP_EN
  input  logic                StepReq,
`endif
  output logic [1:0]          Stage,
  output logic [PC_WIDTH-1:0] PC,
  output logic                Handshake,
  output logic                Stalled,
  output logic                Idle
);

  localparam logic [1:0] LAST_STAGE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [1:0]              stage_q, stage_next;
  logic [PC_WIDTH-1:0]     pc_q, pc_next, pc_adv;
  logic [SYNC_STAGES-1:0]  hs_sync;
  logic                    halt;

  // Next sequential address; wraps on program length, not on counter overflow.
  assign pc_adv = (pc_q == PC_WIDTH'(PROG_LEN - 1)) ? '0 : pc_q + PC_WIDTH'(1);

`ifdef SINGLE_STEP_EN
  logic [SYNC_STAGES-1:0]  step_sync;
  logic                    step_prev;
  logic                    stepping, stepping_next;
  logic                    step_rise;

  assign step_rise = step_sync[SYNC_STAGES-1] & ~step_prev;
  // A single-step instruction always returns to IDLE, whatever Run says.
  assign halt      = ~Run | stepping;
`else
  assign halt      = ~Run;
`endif

  // State register plus synchronisers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      stage_q   <= '0;
      pc_q      <= '0;
      hs_sync   <= '0;
`ifdef SINGLE_STEP_EN
      step_sync <= '0;
      step_prev <= 1'b0;
      stepping  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      stage_q   <= stage_next;
      pc_q      <= pc_next;
      hs_sync   <= {hs_sync[SYNC_STAGES-2:0], HandshakeIn};
`ifdef SINGLE_STEP_EN
      step_sync <= {step_sync[SYNC_STAGES-2:0], StepReq};
      // Tracked every cycle so edges seen outside IDLE are consumed and dropped.
      step_prev <= step_sync[SYNC_STAGES-1];
      stepping  <= stepping_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    stage_next = stage_q;
    pc_next    = pc_q;
`ifdef SINGLE_STEP_EN
    stepping_next = stepping;
`endif
    case (state)
      ST_IDLE: begin
        // Stage stays 0 on the start edge so the first RUN cycle is the fetch.
        stage_next = 2'd0;
`ifdef SINGLE_STEP_EN
        if (step_rise) begin
          state_next    = ST_RUN;
          stepping_next = 1'b1;
        end else if (Run) begin
          state_next    = ST_RUN;
          stepping_next = 1'b0;
        end
`else
        if (Run) state_next = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (stage_q != LAST_STAGE) begin
          stage_next = stage_q + 2'd1;
        end else if (PCHold) begin
          state_next = ST_WAIT;
        end else begin
          stage_next = 2'd0;
          pc_next    = pc_adv;
          state_next = halt ? ST_IDLE : ST_RUN;
`ifdef SINGLE_STEP_EN
          if (halt) stepping_next = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        // Run is not looked at until the hold clears.
        if (!PCHold) begin
          stage_next = 2'd0;
          pc_next    = pc_adv;
          state_next = halt ? ST_IDLE : ST_RUN;
`ifdef SINGLE_STEP_EN
          if (halt) stepping_next = 1'b0;
`endif
        end
      end
      default: begin
        state_next = ST_IDLE;
        stage_next = 2'd0;
      end
    endcase
  end

  // Outputs decoded straight from registers
  always_comb begin
    Stage     = stage_q;
    PC        = pc_q;
    Handshake = hs_sync[SYNC_STAGES-1];
    Stalled   = (state == ST_WAIT);
    Idle      = (state == ST_IDLE);
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Sequences the picoMips datapath through its four-phase instruction cycle.
- Generates the 2-bit Stage code and the program counter.
- Resolves PC hold requests from the instruction decoder.
- Synchronises the external handshake line before the decoder sees it. Sits between the program ROM address port and the decoder/register file/accumulator.

Parameters:
PC_WIDTH, 8, width of program counter / ROM address
PROG_LEN, 256, number of program words; PC wraps to 0 after PROG_LEN-1 (2 <= PROG_LEN <= 2**PC_WIDTH)
SYNC_STAGES, 2, flops in handshake synchroniser (>= 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
Run  input  1  high enables sequencing; low freezes Stage and PC at next stage-0 boundary
HandshakeIn  input  1  asynchronous external handshake line
PCHold  input  1  hold request from decoder, sampled only in stage 3
Stage  output  2  current phase: 0 fetch, 1 decode, 2 execute, 3 writeback
PC  output  PC_WIDTH  current instruction address
Handshake  output  1  synchronised HandshakeIn, to decoder
Stalled  output  1  high while in WAIT state
Idle  output  1  high while in IDLE state

Behaviour:
- Reset (reset high at clk edge): state IDLE, Stage=0, PC=0, all synchroniser flops=0, so Handshake=0, Stalled=0, Idle=1. Reset overrides everything, including mid-WAIT.
- States: IDLE, RUN, WAIT.
- IDLE: Stage=0, PC held, Idle=1. Run=1 -> RUN next cycle; Stage stays 0 on that edge, so first fetch occupies the first RUN cycle.
- RUN, Stage 0..2: Stage increments by 1 each cycle; PC unchanged.
- RUN, Stage 3, PCHold=0:
  - Stage -> 0.
  - PC -> (PC == PROG_LEN-1) ? 0 : PC+1.
  - If Run=0 at the same edge, state -> IDLE with the advanced PC, so the next start resumes at the following instruction.
- RUN, Stage 3, PCHold=1: state -> WAIT; Stage stays 3, PC unchanged.
- WAIT: Stalled=1, Stage=3, PC frozen.
  - PCHold=0 at an edge: Stage -> 0, PC advances per the wrap rule, state -> RUN, or -> IDLE if Run=0.
  - Run is ignored while PCHold=1, so a halt request cannot abandon a pending handshake.
- Run deasserted in stages 0..2: the current instruction completes; the transition out of stage 3 applies the rule above.
- Instruction latency: 4 cycles per instruction without hold; each held cycle adds 1.
- Handshake: SYNC_STAGES-deep shift chain from HandshakeIn. Handshake is the last flop, giving SYNC_STAGES cycles latency; no debounce.
- PC arithmetic: unsigned, PC_WIDTH bits. The wrap compare is on PROG_LEN-1, not natural overflow.
- Outputs are registered, or decoded directly from state registers. No combinational path from PCHold to Stage or PC.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input StepReq (1 bit, synchronised through its own SYNC_STAGES-deep chain).
  - A rising edge of the synchronised StepReq in IDLE runs exactly one instruction: four stages, plus WAIT if held, then returns to IDLE with PC advanced by one, independent of Run.
  - Step requests arriving outside IDLE are dropped.
- Undefined: no StepReq port; behaviour exactly as above.

Test Plan:
- Reset then Run=1, PCHold=0 for 12 cycles -> Stage sequence 0,0,1,2,3,0,1,2,3,0,1,2; PC 0 for the first 5 cycles, then 1, then 2; Idle falls after the first edge.
- PROG_LEN=5, free run -> PC sequence 0,1,2,3,4,0, with each value held 4 cycles; no value 5 ever appears.
- PCHold=1 in stage 3 of PC=3 for 6 cycles -> Stalled=1 for 6 cycles, Stage=3 and PC=3 throughout; PCHold drops -> next cycle Stage=0, PC=4, Stalled=0.
- HandshakeIn 0->1 -> Handshake rises exactly SYNC_STAGES cycles later; a 1-cycle glitch is passed through delayed, not filtered.
- Run=0 asserted during stage 1 of PC=7 -> stages 2,3 complete, then Idle=1, PC=8, Stage=0; Run=1 -> sequencing resumes at PC=8. Reset asserted mid-WAIT -> next cycle IDLE, PC=0, Stalled=0.
- With SINGLE_STEP_EN defined, Run=0, one StepReq pulse -> after synchroniser delay, one full 4-stage pass, PC 0->1, back to Idle=1; a second pulse mid-step is ignored.
